vedic_product_accumulator: RTL and testbench

- Downstream stage of the 2x2 vedic multiplier.
- Consumes its registered `product` stream one beat per cycle and sums a fixed-length frame of products into a saturating accumulator.
- Presents each frame total on a valid/ready output with a per-frame overflow flag.
- Applies backpressure to the product stream only when a completed frame cannot be handed off.

---
 rtl/vedic_pkg.sv | 14 +
 rtl/vedic_sat_add.sv | 18 +
 rtl/vedic_product_accumulator.sv | 110 +++++++++++
 tb/tb_vedic_product_accumulator.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Types and default widths shared by the vedic multiplier stage and its
// downstream product accumulator.
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam int DEFAULT_PROD_W = 5;
    localparam int DEFAULT_ACC_W  = 8;

endpackage

// File: rtl/vedic_sat_add.sv
// Combinational W-bit unsigned adder that clamps to all-ones on carry-out
// and reports the carry so callers can track overflow.
module vedic_sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] raw;

    assign raw   = {1'b0, a} + {1'b0, b};
    assign carry = raw[W];
    assign sum   = raw[W] ? {W{1'b1}} : raw[W-1:0];

endmodule

// File: rtl/vedic_product_accumulator.sv
// Sums fixed-length frames of multiplier products into a saturating total and
// hands each total off on a valid/ready port with a sticky overflow flag.
module vedic_product_accumulator
    import vedic_pkg::*;
#(
    parameter int PROD_W    = DEFAULT_PROD_W,
    parameter int FRAME_LEN = 4,
    parameter int ACC_W     = DEFAULT_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PROD_W-1:0] product,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic              clear,
    output logic [ACC_W-1:0]  sum,
    output logic              overflow,
    output logic              sum_valid,
    input  logic              sum_ready
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic               ovf_reg, ovf_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic               last_beat;
    logic               out_blocked;
    logic               accept;
    logic               load;

    vedic_sat_add #(.W(ACC_W)) u_sat_add (
        .a     (acc_reg),
        .b     (ACC_W'(product)),
        .sum   (add_sum),
        .carry (add_carry)
    );

    assign last_beat   = (cnt_reg == LAST);
    assign out_blocked = sum_valid && !sum_ready;
    // Only the closing beat needs the result register, so only it can stall.
    assign prod_ready  = !(last_beat && out_blocked) && !reset;
    assign accept      = prod_valid && prod_ready;
    assign load        = accept && last_beat && !clear;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;
        cnt_next   = cnt_reg;
        if (clear) begin
            // Any beat accepted alongside clear is swallowed.
            state_next = IDLE;
            acc_next   = '0;
            ovf_next   = 1'b0;
            cnt_next   = '0;
        end else if (accept) begin
            if (last_beat) begin
                state_next = IDLE;
                acc_next   = '0;
                ovf_next   = 1'b0;
                cnt_next   = '0;
            end else begin
                state_next = ACCUM;
                acc_next   = add_sum;
                ovf_next   = ovf_reg | add_carry;
                cnt_next   = cnt_reg + CNT_W'(1);
            end
        end else if (last_beat && out_blocked) begin
            state_next = STALL;
        end else if (state_reg == STALL) begin
            state_next = ACCUM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
            cnt_reg   <= cnt_next;
        end
    end

    // A fresh load takes priority over draining, so frames pass with no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum       <= '0;
            overflow  <= 1'b0;
            sum_valid <= 1'b0;
        end else if (load) begin
            sum       <= add_sum;
            overflow  <= ovf_reg | add_carry;
            sum_valid <= 1'b1;
        end else if (sum_valid && sum_ready) begin
            sum_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vedic_product_accumulator.sv
// Directed bench for the product accumulator: default instance plus a
// narrow 6-bit, 8-beat instance for the saturation case.
module tb_vedic_product_accumulator;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] product;
    logic       prod_valid, prod_ready, clear;
    logic [7:0] sum;
    logic       overflow, sum_valid, sum_ready;

    logic [4:0] product6;
    logic       prod_valid6, prod_ready6, clear6;
    logic [5:0] sum6;
    logic       overflow6, sum_valid6, sum_ready6;

    int n_checks = 0;
    int n_pass   = 0;

    vedic_product_accumulator dut (
        .clk        (clk),
        .reset      (reset),
        .product    (product),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .clear      (clear),
        .sum        (sum),
        .overflow   (overflow),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready)
    );

    vedic_product_accumulator #(.PROD_W(5), .FRAME_LEN(8), .ACC_W(6)) dut6 (
        .clk        (clk),
        .reset      (reset),
        .product    (product6),
        .prod_valid (prod_valid6),
        .prod_ready (prod_ready6),
        .clear      (clear6),
        .sum        (sum6),
        .overflow   (overflow6),
        .sum_valid  (sum_valid6),
        .sum_ready  (sum_ready6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %s: %0d ok", tag, got);
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [4:0] v);
        product    = v;
        prod_valid = 1'b1;
        $display("beat product=%0d prod_ready=%0d", v, prod_ready);
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic beat6(input logic [4:0] v);
        product6    = v;
        prod_valid6 = 1'b1;
        $display("beat6 product=%0d prod_ready=%0d", v, prod_ready6);
        tick();
        prod_valid6 = 1'b0;
    endtask

    initial begin
        logic [4:0] b2b [8];
        b2b = '{5'd9, 5'd9, 5'd9, 5'd9, 5'd0, 5'd1, 5'd0, 5'd1};

        reset = 1'b1; product = '0; prod_valid = 1'b0; clear = 1'b0; sum_ready = 1'b0;
        product6 = '0; prod_valid6 = 1'b0; clear6 = 1'b0; sum_ready6 = 1'b1;
        #1;
        check("rst_prod_ready", prod_ready, 0);
        check("rst_sum_valid", sum_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_overflow", overflow, 0);
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rel_prod_ready", prod_ready, 1);

        // Single frame 1,4,9,2
        sum_ready = 1'b1;
        beat(5'd1); beat(5'd4); beat(5'd9);
        check("f1_not_yet", sum_valid, 0);
        beat(5'd2);
        check("f1_valid", sum_valid, 1);
        check("f1_sum", sum, 16);
        check("f1_ovf", overflow, 0);
        tick();
        check("f1_one_cycle", sum_valid, 0);
        check("f1_sum_hold", sum, 16);

        // Back-to-back frames with continuous valid
        for (int i = 0; i < 8; i++) begin
            product    = b2b[i];
            prod_valid = 1'b1;
            check("b2b_ready", prod_ready, 1);
            $display("beat product=%0d prod_ready=%0d", b2b[i], prod_ready);
            tick();
            if (i == 3) begin
                check("b2b_sum0", sum, 36);
                check("b2b_valid0", sum_valid, 1);
            end
            if (i == 4) check("b2b_drain", sum_valid, 0);
        end
        prod_valid = 1'b0;
        check("b2b_sum1", sum, 2);
        check("b2b_valid1", sum_valid, 1);
        check("b2b_ovf1", overflow, 0);
        tick();

        // Narrow instance: saturation then clean frame
        for (int i = 0; i < 8; i++) beat6(5'd9);
        check("sat_sum", sum6, 63);
        check("sat_ovf", overflow6, 1);
        check("sat_valid", sum_valid6, 1);
        for (int i = 0; i < 8; i++) beat6(5'd1);
        check("ones_sum", sum6, 8);
        check("ones_ovf", overflow6, 0);

        // Backpressure on the final beat only
        sum_ready = 1'b0;
        beat(5'd1); beat(5'd4); beat(5'd9); beat(5'd2);
        check("bp_sum", sum, 16);
        check("bp_valid", sum_valid, 1);
        for (int i = 0; i < 3; i++) begin
            check("bp_ready_early", prod_ready, 1);
            beat(5'd1);
        end
        product = 5'd1;
        prod_valid = 1'b1;
        check("bp_ready_last", prod_ready, 0);
        tick(); tick();
        check("bp_ready_held", prod_ready, 0);
        check("bp_sum_held", sum, 16);
        check("bp_valid_held", sum_valid, 1);
        sum_ready = 1'b1;
        #1;
        check("bp_ready_free", prod_ready, 1);
        tick();
        prod_valid = 1'b0;
        check("bp_new_sum", sum, 4);
        check("bp_no_bubble", sum_valid, 1);
        tick();
        check("bp_drained", sum_valid, 0);

        // Clear after two beats; beat with clear is dropped
        beat(5'd4); beat(5'd4);
        product = 5'd7; prod_valid = 1'b1; clear = 1'b1;
        tick();
        prod_valid = 1'b0; clear = 1'b0;
        check("clr_no_result", sum_valid, 0);
        beat(5'd1); beat(5'd1); beat(5'd1);
        check("clr_not_early", sum_valid, 0);
        beat(5'd1);
        check("clr_sum", sum, 4);
        check("clr_valid", sum_valid, 1);
        tick();

        // Reset mid-frame with a pending result
        sum_ready = 1'b0;
        beat(5'd3); beat(5'd3); beat(5'd3); beat(5'd3);
        check("pre_rst_sum", sum, 12);
        beat(5'd1); beat(5'd1); beat(5'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", sum_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_ready", prod_ready, 0);
        #1;
        reset = 1'b0;
        sum_ready = 1'b1;
        #1;
        check("post_rst_ready", prod_ready, 1);
        beat(5'd2); beat(5'd2); beat(5'd2);
        check("post_rst_early", sum_valid, 0);
        beat(5'd2);
        check("post_rst_sum", sum, 8);
        check("post_rst_valid", sum_valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
